// File: rtl/frame_buffer_pool.sv
// N-buffer frame store ownership manager: one producer, NUM_READERS consumers.
// Hands out the latest committed frame to readers and a free buffer to the writer.
module frame_buffer_pool #(
  parameter int NUM_BUFFERS = 3,
  parameter int NUM_READERS = 1,
  parameter int ADDR_WIDTH  = 21,
  parameter int FRAME_WORDS = 307200,
  parameter int GUARD_WORDS = 32,
  parameter int BASE_ADDR   = 0,
  parameter int SEQ_WIDTH   = 16,
  localparam int IDW = $clog2(NUM_BUFFERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_acq_req,
  output logic                              wr_acq_ack,
  output logic [IDW-1:0]                    wr_buf_id,
  output logic [ADDR_WIDTH-1:0]             wr_base_addr,
  input  logic                              wr_commit,
  input  logic                              wr_abort,
  input  logic [NUM_READERS-1:0]            rd_acq_req,
  output logic [NUM_READERS-1:0]            rd_acq_ack,
  output logic [NUM_READERS*IDW-1:0]        rd_buf_id,
  output logic [NUM_READERS*ADDR_WIDTH-1:0] rd_base_addr,
  output logic [NUM_READERS-1:0]            rd_repeat,
  input  logic [NUM_READERS-1:0]            rd_release,
  output logic [SEQ_WIDTH-1:0]              frame_seq,
  output logic [SEQ_WIDTH-1:0]              dropped_frames,
  output logic                              error
);

  localparam int NR     = NUM_READERS;
  localparam int NB     = NUM_BUFFERS;
  localparam int SLW    = $clog2(NUM_READERS + 2);
  localparam int STRIDE = FRAME_WORDS + GUARD_WORDS;
  localparam bit PARAM_BAD = (NB < 2) || (NB > 8) || (NR < 1) ||
                             (NR > 4) || (NB < NR + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_GRANT
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] base_of(
    input logic [IDW-1:0] id
  );
    return ADDR_WIDTH'(BASE_ADDR) +
           ADDR_WIDTH'(id) * ADDR_WIDTH'(STRIDE);
  endfunction

  state_t                state_q, state_d;
  logic [NR:0]           cap_q, cap_d;
  logic [SLW-1:0]        last_q, last_d;
  logic [SLW-1:0]        sel_slot_q, sel_slot_d;
  logic [IDW-1:0]        sel_buf_q, sel_buf_d;

  logic [NB-1:0]         writing_q, writing_d;
  logic [NR-1:0]         mask_q [NB];
  logic [NR-1:0]         mask_d [NB];
  logic [NB-1:0]         read_once_q, read_once_d;
  logic [SEQ_WIDTH-1:0]  seq_q [NB];
  logic [SEQ_WIDTH-1:0]  seq_d [NB];
  logic                  latest_valid_q, latest_valid_d;
  logic [IDW-1:0]        latest_id_q, latest_id_d;
  logic [SEQ_WIDTH-1:0]  frame_seq_q, frame_seq_d;
  logic [SEQ_WIDTH-1:0]  dropped_q, dropped_d;
  logic                  error_q, error_d;

  logic                  wr_ack_q, wr_ack_d;
  logic [IDW-1:0]        wr_id_q, wr_id_d;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
  logic [NR-1:0]         rd_ack_q, rd_ack_d;
  logic [NR-1:0]         rd_rep_q, rd_rep_d;
  logic [IDW-1:0]        rd_id_q [NR];
  logic [IDW-1:0]        rd_id_d [NR];
  logic [ADDR_WIDTH-1:0] rd_base_q [NR];
  logic [ADDR_WIDTH-1:0] rd_base_d [NR];
  logic [SEQ_WIDTH-1:0]  last_seq_q [NR];
  logic [SEQ_WIDTH-1:0]  last_seq_d [NR];
  logic [NR-1:0]         prev_vld_q, prev_vld_d;

  logic                  free_found;
  logic [IDW-1:0]        free_id;
  logic                  wr_own;
  logic [NR-1:0]         rd_own;

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!writing_q[i] && mask_q[i] == '0 &&
          !(latest_valid_q && latest_id_q == IDW'(i))) begin
        free_found = 1'b1;
        free_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    wr_own = writing_q[wr_id_q];
    for (int k = 0; k < NR; k++) begin
      rd_own[k] = mask_q[rd_id_q[k]][k];
    end
  end

  always_comb begin
    logic [NR:0] elig;
    logic        found;
    logic        rd_grant;
    logic        prev_read;
    int          pick;

    state_d        = state_q;
    cap_d          = cap_q;
    last_d         = last_q;
    sel_slot_d     = sel_slot_q;
    sel_buf_d      = sel_buf_q;
    writing_d      = writing_q;
    mask_d         = mask_q;
    read_once_d    = read_once_q;
    seq_d          = seq_q;
    latest_valid_d = latest_valid_q;
    latest_id_d    = latest_id_q;
    frame_seq_d    = frame_seq_q;
    dropped_d      = dropped_q;
    error_d        = error_q;
    wr_ack_d       = 1'b0;
    wr_id_d        = wr_id_q;
    wr_base_d      = wr_base_q;
    rd_ack_d       = '0;
    rd_rep_d       = '0;
    rd_id_d        = rd_id_q;
    rd_base_d      = rd_base_q;
    last_seq_d     = last_seq_q;
    prev_vld_d     = prev_vld_q;
    elig           = '0;
    found          = 1'b0;
    pick           = 0;

    // A reader grant landing on the same edge counts as a read of that frame.
    rd_grant  = (state_q == S_GRANT) && (sel_slot_q != '0);
    prev_read = read_once_q[latest_id_q] ||
                (rd_grant && sel_buf_q == latest_id_q);

    if (wr_commit && wr_own) begin
      writing_d[wr_id_q] = 1'b0;
      if (latest_valid_q && !prev_read && dropped_q != '1)
        dropped_d = dropped_q + SEQ_WIDTH'(1);
      latest_valid_d       = 1'b1;
      latest_id_d          = wr_id_q;
      frame_seq_d          = frame_seq_q + SEQ_WIDTH'(1);
      seq_d[wr_id_q]       = frame_seq_d;
      read_once_d[wr_id_q] = 1'b0;
    end
    if (wr_abort && wr_own && !wr_commit)
      writing_d[wr_id_q] = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (rd_release[k] && rd_own[k])
        mask_d[rd_id_q[k]][k] = 1'b0;
    end

    if ((wr_commit || wr_abort) && !wr_own) error_d = 1'b1;
    if (wr_commit && wr_abort) error_d = 1'b1;
    if (wr_acq_req && wr_own && !wr_ack_q) error_d = 1'b1;
    for (int k = 0; k < NR; k++) begin
      if (rd_release[k] && !rd_own[k]) error_d = 1'b1;
      if (rd_acq_req[k] && rd_own[k] && !rd_ack_q[k])
        error_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cap_d = {rd_acq_req & ~rd_ack_q, wr_acq_req & ~wr_ack_q};
        if (|cap_d) state_d = S_SELECT;
      end
      S_SELECT: begin
        elig[0] = cap_q[0] && free_found;
        for (int k = 0; k < NR; k++)
          elig[k+1] = cap_q[k+1] && latest_valid_q;
        for (int i = 1; i <= NR + 1; i++) begin
          for (int j = 0; j <= NR; j++) begin
            if (!found && elig[j] &&
                j == (int'(last_q) + i) % (NR + 1)) begin
              found = 1'b1;
              pick  = j;
            end
          end
        end
        if (found) begin
          sel_slot_d = SLW'(pick);
          sel_buf_d  = (pick == 0) ? free_id : latest_id_q;
          state_d    = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        state_d = S_IDLE;
        last_d  = sel_slot_q;
        if (sel_slot_q == '0) begin
          writing_d[sel_buf_q] = 1'b1;
          wr_ack_d             = 1'b1;
          wr_id_d              = sel_buf_q;
          wr_base_d            = base_of(sel_buf_q);
        end
        for (int k = 0; k < NR; k++) begin
          if (sel_slot_q == SLW'(k + 1)) begin
            mask_d[sel_buf_q][k]   = 1'b1;
            read_once_d[sel_buf_q] = 1'b1;
            rd_ack_d[k]            = 1'b1;
            rd_id_d[k]             = sel_buf_q;
            rd_base_d[k]           = base_of(sel_buf_q);
            rd_rep_d[k]            = prev_vld_q[k] &&
                                     last_seq_q[k] == seq_q[sel_buf_q];
            last_seq_d[k]          = seq_q[sel_buf_q];
            prev_vld_d[k]          = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cap_q          <= '0;
      last_q         <= SLW'(NR);
      sel_slot_q     <= '0;
      sel_buf_q      <= '0;
      writing_q      <= '0;
      read_once_q    <= '0;
      latest_valid_q <= 1'b0;
      latest_id_q    <= '0;
      frame_seq_q    <= '0;
      dropped_q      <= '0;
      error_q        <= 1'b0;
      wr_ack_q       <= 1'b0;
      wr_id_q        <= '0;
      wr_base_q      <= '0;
      rd_ack_q       <= '0;
      rd_rep_q       <= '0;
      prev_vld_q     <= '0;
      for (int i = 0; i < NB; i++) begin
        mask_q[i] <= '0;
        seq_q[i]  <= '0;
      end
      for (int k = 0; k < NR; k++) begin
        rd_id_q[k]    <= '0;
        rd_base_q[k]  <= '0;
        last_seq_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cap_q          <= cap_d;
      last_q         <= last_d;
      sel_slot_q     <= sel_slot_d;
      sel_buf_q      <= sel_buf_d;
      writing_q      <= writing_d;
      read_once_q    <= read_once_d;
      latest_valid_q <= latest_valid_d;
      latest_id_q    <= latest_id_d;
      frame_seq_q    <= frame_seq_d;
      dropped_q      <= dropped_d;
      error_q        <= error_d;
      wr_ack_q       <= wr_ack_d;
      wr_id_q        <= wr_id_d;
      wr_base_q      <= wr_base_d;
      rd_ack_q       <= rd_ack_d;
      rd_rep_q       <= rd_rep_d;
      prev_vld_q     <= prev_vld_d;
      mask_q         <= mask_d;
      seq_q          <= seq_d;
      rd_id_q        <= rd_id_d;
      rd_base_q      <= rd_base_d;
      last_seq_q     <= last_seq_d;
    end
  end

  assign wr_acq_ack     = wr_ack_q;
  assign wr_buf_id      = wr_id_q;
  assign wr_base_addr   = wr_base_q;
  assign rd_acq_ack     = rd_ack_q;
  assign rd_repeat      = rd_rep_q;
  assign frame_seq      = frame_seq_q;
  assign dropped_frames = dropped_q;
  assign error          = error_q | PARAM_BAD;

  for (genvar k = 0; k < NR; k++) begin : g_rd_out
    assign rd_buf_id[k*IDW +: IDW]               = rd_id_q[k];
    assign rd_base_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = rd_base_q[k];
  end

endmodule

// File: tb/tb_frame_buffer_pool.sv
// Directed bench for frame_buffer_pool: single-reader instance plus a
// two-reader instance for round-robin contention.
module tb_frame_buffer_pool;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_acq_req, wr_acq_ack, wr_commit, wr_abort;
  logic [1:0]  wr_buf_id;
  logic [20:0] wr_base_addr;
  logic [0:0]  rd_acq_req, rd_acq_ack, rd_repeat, rd_release;
  logic [1:0]  rd_buf_id;
  logic [20:0] rd_base_addr;
  logic [15:0] frame_seq, dropped_frames;
  logic        error;

  logic        w1_req, w1_ack, w1_commit, w1_abort;
  logic [1:0]  w1_id;
  logic [20:0] w1_base;
  logic [1:0]  r1_req, r1_ack, r1_rep, r1_rel;
  logic [3:0]  r1_id;
  logic [41:0] r1_base;
  logic [15:0] seq1, drop1;
  logic        err1;

  frame_buffer_pool u0 (
    .clk(clk), .rst_n(rst_n),
    .wr_acq_req(wr_acq_req), .wr_acq_ack(wr_acq_ack),
    .wr_buf_id(wr_buf_id), .wr_base_addr(wr_base_addr),
    .wr_commit(wr_commit), .wr_abort(wr_abort),
    .rd_acq_req(rd_acq_req), .rd_acq_ack(rd_acq_ack),
    .rd_buf_id(rd_buf_id), .rd_base_addr(rd_base_addr),
    .rd_repeat(rd_repeat), .rd_release(rd_release),
    .frame_seq(frame_seq), .dropped_frames(dropped_frames),
    .error(error)
  );

  frame_buffer_pool #(.NUM_BUFFERS(4), .NUM_READERS(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_acq_req(w1_req), .wr_acq_ack(w1_ack),
    .wr_buf_id(w1_id), .wr_base_addr(w1_base),
    .wr_commit(w1_commit), .wr_abort(w1_abort),
    .rd_acq_req(r1_req), .rd_acq_ack(r1_ack),
    .rd_buf_id(r1_id), .rd_base_addr(r1_base),
    .rd_repeat(r1_rep), .rd_release(r1_rel),
    .frame_seq(seq1), .dropped_frames(drop1),
    .error(err1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_acq(output int lat);
    wr_acq_req = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!wr_acq_ack && lat < 50);
    wr_acq_req = 1'b0;
  endtask

  task automatic rd_acq(output int lat);
    rd_acq_req[0] = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!rd_acq_ack[0] && lat < 50);
    rd_acq_req[0] = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
  endtask

  task automatic rd_rel();
    rd_release[0] = 1'b1;
    step();
    rd_release[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, n, coll;
    int t_w, t_r0, t_r1;
    logic [1:0] id_w, id_r0, id_r1;
    logic [20:0] base_w;
    logic rep0, rep1;

    wr_acq_req = 0; wr_commit = 0; wr_abort = 0;
    rd_acq_req = 0; rd_release = 0;
    w1_req = 0; w1_commit = 0; w1_abort = 0;
    r1_req = 0; r1_rel = 0;

    // reset behaviour, with a request held during reset
    rst_n = 1'b0;
    wr_acq_req = 1'b1;
    n = 0;
    repeat (6) begin
      step();
      if (wr_acq_ack) n++;
    end
    chk("ack_in_reset", n, 0);
    wr_acq_req = 1'b0;
    chk("rst_wr_id", wr_buf_id, 0);
    chk("rst_wr_addr", wr_base_addr, 0);
    chk("rst_rd_ack", rd_acq_ack, 0);
    chk("rst_rd_rep", rd_repeat, 0);
    chk("rst_seq", frame_seq, 0);
    chk("rst_drop", dropped_frames, 0);
    chk("rst_err", error, 0);
    rst_n = 1'b1;
    step();
    step();

    // reader before any commit gets nothing
    rd_acq_req[0] = 1'b1;
    n = 0;
    repeat (100) begin
      step();
      if (rd_acq_ack[0]) n++;
    end
    chk("rd_no_commit", n, 0);
    rd_acq_req[0] = 1'b0;
    step();
    step();

    wr_acq(lat);
    chk("wr_lat", lat, 3);
    chk("wr_id0", wr_buf_id, 0);
    chk("wr_addr0", wr_base_addr, 0);
    step();
    chk("wr_ack_pulse", wr_acq_ack, 0);
    commit();
    chk("seq1", frame_seq, 1);

    rd_acq(lat);
    chk("rd_lat", lat, 3);
    chk("rd_id0", rd_buf_id, 0);
    chk("rd_addr0", rd_base_addr, 0);
    chk("rd_rep0", rd_repeat, 0);
    step();
    rd_rel();
    rd_acq(lat);
    chk("rd_reacq_id", rd_buf_id, 0);
    chk("rd_reacq_rep", rd_repeat, 1);
    step();

    // reader holds buffer 0 (latest) -> writer gets 1, then 2
    wr_acq(lat);
    chk("wr_id1", wr_buf_id, 1);
    chk("wr_addr1", wr_base_addr, 307232);
    commit();
    chk("seq2", frame_seq, 2);
    chk("drop_after2", dropped_frames, 0);
    wr_acq(lat);
    chk("wr_id2", wr_buf_id, 2);
    chk("wr_addr2", wr_base_addr, 614464);
    commit();
    chk("seq3", frame_seq, 3);
    chk("drop_after3", dropped_frames, 1);

    wr_acq(lat);
    chk("wr_id_abort", wr_buf_id, 1);
    wr_abort = 1'b1;
    step();
    wr_abort = 1'b0;
    chk("abort_seq", frame_seq, 3);
    chk("abort_err", error, 0);

    // reset mid-frame
    wr_acq(lat);
    chk("wr_id_again", wr_buf_id, 1);
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_wr_id", wr_buf_id, 0);
    chk("mid_rst_wr_addr", wr_base_addr, 0);
    chk("mid_rst_rd_id", rd_buf_id, 0);
    chk("mid_rst_seq", frame_seq, 0);
    chk("mid_rst_drop", dropped_frames, 0);
    rst_n = 1'b1;
    step();

    // three commits, no reader -> two drops
    wr_acq(lat);
    chk("post_rst_id", wr_buf_id, 0);
    commit();
    wr_acq(lat);
    chk("drop_seq_id1", wr_buf_id, 1);
    commit();
    wr_acq(lat);
    chk("drop_seq_id0", wr_buf_id, 0);
    commit();
    chk("drop_seq3", frame_seq, 3);
    chk("dropped2", dropped_frames, 2);
    rd_acq(lat);
    chk("rd_latest_id", rd_buf_id, 0);
    chk("rd_latest_rep", rd_repeat, 0);
    step();

    // protocol error on spurious release
    rd_rel();
    chk("legal_rel_err", error, 0);
    rd_rel();
    chk("bad_rel_err", error, 1);
    repeat (5) step();
    chk("err_sticky", error, 1);
    rst_n = 1'b0;
    step();
    chk("err_cleared", error, 0);
    rst_n = 1'b1;
    step();

    // two-reader instance: contention
    w1_req = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!w1_ack && lat < 50);
    w1_req = 1'b0;
    chk("u1_wr_lat", lat, 3);
    chk("u1_wr_id0", w1_id, 0);
    w1_commit = 1'b1;
    step();
    w1_commit = 1'b0;
    chk("u1_seq1", seq1, 1);

    w1_req = 1'b1;
    r1_req = 2'b11;
    coll = 0;
    t_w = 0; t_r0 = 0; t_r1 = 0;
    id_w = '1; id_r0 = '1; id_r1 = '1;
    base_w = '0; rep0 = 1'b1; rep1 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if ($countones({w1_ack, r1_ack}) > 1) coll++;
      if (w1_ack) begin
        t_w = c; id_w = w1_id; base_w = w1_base; w1_req = 1'b0;
      end
      if (r1_ack[0]) begin
        t_r0 = c; id_r0 = r1_id[1:0]; rep0 = r1_rep[0];
        r1_req[0] = 1'b0;
      end
      if (r1_ack[1]) begin
        t_r1 = c; id_r1 = r1_id[3:2]; rep1 = r1_rep[1];
        r1_req[1] = 1'b0;
      end
    end
    w1_req = 1'b0;
    r1_req = 2'b00;
    chk("rr_collisions", coll, 0);
    chk("rr_t_r0", t_r0, 3);
    chk("rr_t_r1", t_r1, 6);
    chk("rr_t_w", t_w, 9);
    chk("rr_id_r0", id_r0, 0);
    chk("rr_id_r1", id_r1, 0);
    chk("rr_rep_r0", rep0, 0);
    chk("rr_rep_r1", rep1, 0);
    chk("rr_id_w", id_w, 1);
    chk("rr_base_w", base_w, 307232);

    r1_rel = 2'b10;
    step();
    r1_rel = 2'b00;
    chk("u1_legal_rel", err1, 0);
    r1_rel = 2'b10;
    step();
    r1_rel = 2'b00;
    chk("u1_bad_rel", err1, 1);
    step();
    chk("u1_err_sticky", err1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_buffer_pool.md
Name: frame_buffer_pool

Overview:
- Generalised N-buffer ownership manager for the pSRAM frame store: one producer (frame uploader) and NUM_READERS consumers (downloaders/processors).
- Hands out buffer IDs and base addresses under a "latest committed frame" policy.
- Tracks per-buffer writer/reader ownership, frame sequence numbers, dropped and repeated frames.
- Replaces the fixed triple-buffer controller plus buffer-metadata arbitration in the video controller.

Parameters:
- NUM_BUFFERS, 3, number of frame buffers (2..8); must satisfy NUM_BUFFERS >= NUM_READERS+2.
- NUM_READERS, 1, number of consumer clients (1..4).
- ADDR_WIDTH, 21, memory word address width.
- FRAME_WORDS, 307200, words per frame.
- GUARD_WORDS, 32, gap between consecutive buffers.
- BASE_ADDR, 0, address of buffer 0.
- SEQ_WIDTH, 16, width of sequence and drop counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_acq_req  in  1  level; producer requests a buffer, held until ack.
- wr_acq_ack  out  1  one-cycle grant pulse.
- wr_buf_id  out  IDW=$clog2(NUM_BUFFERS)  granted buffer; held until next writer grant.
- wr_base_addr  out  ADDR_WIDTH  base of wr_buf_id.
- wr_commit  in  1  pulse; writer done, frame becomes latest.
- wr_abort  in  1  pulse; writer done, buffer returned FREE without commit.
- rd_acq_req  in  NUM_READERS  per-reader level request.
- rd_acq_ack  out  NUM_READERS  per-reader one-cycle grant pulse.
- rd_buf_id  out  NUM_READERS*IDW  per-reader granted buffer.
- rd_base_addr  out  NUM_READERS*ADDR_WIDTH  per-reader base address.
- rd_repeat  out  NUM_READERS  valid with ack; granted frame has the same sequence number as that reader's previous grant.
- rd_release  in  NUM_READERS  per-reader pulse; reader done.
- frame_seq  out  SEQ_WIDTH  sequence number of latest committed frame.
- dropped_frames  out  SEQ_WIDTH  committed frames superseded without being read; saturating.
- error  out  1  sticky protocol error.

Behaviour:
- Address: base(i) = BASE_ADDR + i*(FRAME_WORDS+GUARD_WORDS), truncated to ADDR_WIDTH; registered with the ack.
- Per-buffer state:
  - writing flag.
  - reader mask (NUM_READERS bits).
  - read_once flag.
  - seq (SEQ_WIDTH).
  - Global: latest_valid, latest_id.
- Reset: all buffers FREE, masks 0, latest_valid=0, every ack/id/addr/rd_repeat 0, frame_seq=0, dropped_frames=0, error=0, FSM in IDLE. Reset asserted mid-frame discards all ownership; no ack pulses may appear while rst_n is low.
- Releases are processed at every clock edge independent of the FSM:
  - wr_commit: clear writing; latest_id<=buffer; latest_valid<=1; frame_seq+1 (wraps); buffer seq<=new frame_seq; read_once<=0.
  - If the previous latest buffer had read_once=0, dropped_frames+1 (saturates at all-ones).
  - wr_abort: clear writing only.
  - rd_release[k]: clear mask bit k of that reader's buffer.
- Acquisition FSM, one grant at a time:
  - IDLE: if any request, capture all requests, go to SELECT.
  - SELECT: round-robin among writer (slot 0) and readers (slots 1..NUM_READERS), starting after the last granted slot. Candidate eligibility:
    - Writer: needs a buffer with writing=0, mask=0 and not latest; pick the lowest index.
    - Reader: needs latest_valid=1.
    - If no captured requester is eligible, return to IDLE.
    - Otherwise record the choice and go to GRANT.
  - GRANT: update ownership (writer: writing<=1; reader: set mask bit, read_once<=1), drive the ack pulse, outputs and rd_repeat, then go to IDLE.
  - Uncontested latency: request high at edge n → ack high during cycle n+3. A requester must drop its req in the cycle after its ack.
- Selection uses registered state: a commit on the same edge as SELECT is not visible, so a reader gets the previous latest frame.
- Buffer selection during SELECT and a release during GRANT are independent by construction: a writer can never be handed a buffer with a nonzero mask.
- error set (sticky) on any of:
  - wr_commit/wr_abort with no writer-owned buffer.
  - wr_commit and wr_abort in the same cycle.
  - rd_release[k] with reader k owning nothing.
  - Acquire request while that client already owns a buffer.
  - Illegal parameters (static check, error tied high).

Test Plan:
- After reset, wr_acq_req=1 at edge 0 → wr_acq_ack in cycle 3, wr_buf_id=0, wr_base_addr=0. wr_commit → frame_seq=1.
- Second writer acquire while buffer 0 is latest → wr_buf_id=1, wr_base_addr=307232. Third → id=2, addr=614464 (default params).
- rd_acq_req[0] before any commit → no ack for 100 cycles. After the first commit → ack, rd_buf_id=0, rd_repeat=0. Release and reacquire with no new commit → same id, rd_repeat=1.
- Writer commits 3 frames with no reader acquiring → dropped_frames=2, frame_seq=3. Reader then gets the buffer holding seq 3.
- NUM_READERS=2, both readers and the writer request in the same cycle → three acks in round-robin order, no two in the same cycle, writer never handed a reader-held buffer.
- rd_release[1] with nothing owned → error=1, held until rst_n low. Assert rst_n mid-frame → all outputs zero, next writer grant returns id 0.
